barrier_ctrl: RTL and testbench
===============================

BARRIER_CTRL -- requirements
Module: barrier_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH_SPEED, default 14, speed width; SPEED_LIMIT, default 60, max speed allowed to open the barrier; WIDTH_TMR, default 20, timer width; MOTOR_TMO, default 500000, max cycles for a motor travel; HOLD_CYC, default 50000, cycles the barrier stays open after the last vehicle passes; PASS_TMO, default 2000000, max cycles open with no pass.
REQ-002 SHALL have ports, one clock and one reset: clk  in  1  system clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 done  in  1  one-cycle pulse from the toll datapath; speed and en_barrier are valid in that cycle.
REQ-005 en_barrier  in  1  Epass authorisation for the vehicle reported by done.
REQ-006 speed  in  WIDTH_SPEED  measured vehicle speed, unsigned.
REQ-007 sensor3  in  1  exit loop, high while a vehicle is under the barrier.
REQ-008 lim_open, lim_closed  in  1 each  barrier limit switches, high at end of travel.
REQ-009 fault_clr  in  1  operator fault clear, level.
REQ-010 motor_up, motor_down  out  1 each  motor drive, registered, never both high.
REQ-011 barrier_open  out  1  high only in state OPEN; reject  out  1  one-cycle pulse for a refused vehicle; overspeed  out  1  one-cycle pulse when speed > SPEED_LIMIT; fault  out  1  high in state FAULT; pending  out  2  vehicles authorised but not yet past.

Function
REQ-012 SHALL implement FSM states CLOSED, OPENING, OPEN, CLOSING, FAULT. All outputs are registered.
REQ-013 Authorised vehicle = done & en_barrier & (speed <= SPEED_LIMIT). This increments pending, which saturates at 3, in any state except FAULT.
REQ-014 done & (!en_barrier | speed > SPEED_LIMIT) pulses reject the next cycle. overspeed also pulses if speed > SPEED_LIMIT. pending is unchanged.
REQ-015 A pass is a sensor3 rising edge, detected against a registered copy of sensor3. A pass decrements pending, which floors at 0. An increment and a decrement in the same cycle leave pending unchanged.
REQ-016 CLOSED: motors off. Go to OPENING when pending != 0 or an authorised done occurs.
REQ-017 OPENING: motor_up = 1 and the timer counts. lim_open -> OPEN. Timer == MOTOR_TMO-1 -> FAULT.
REQ-018 OPEN: timer restarts on entry, on each pass and on each authorised done. If pending == 0 and sensor3 is low, go to CLOSING once the timer reaches HOLD_CYC-1. If pending != 0, go to CLOSING once the timer reaches PASS_TMO-1, and clear pending to 0.
REQ-019 CLOSING: motor_down = 1 and the timer counts. sensor3 high or an authorised done -> OPENING (safety reversal, timer cleared). lim_closed -> CLOSED. Timeout -> FAULT.
REQ-020 FAULT: motors off, fault = 1, pending held at 0, done ignored. fault_clr -> CLOSING.
REQ-021 lim_open and lim_closed both high in any state -> FAULT on the next cycle.
REQ-022 Each state transition takes exactly one cycle. Motor outputs change in the cycle after the transition decision.
REQ-023 The timer SHALL be WIDTH_TMR bits and never wrap. It clears on every state change.

Reset
REQ-024 Reset SHALL force state CLOSED, pending = 0, timer = 0 and the sensor3 history = 0. All outputs go to 0.
REQ-025 Reset asserted mid-travel SHALL drop motor drive on the next clk edge. After reset the block does not re-open until a new authorised done arrives.

Structure
REQ-026 A shared package SHALL hold the state enum, its 3-bit encoding and default parameter constants. The toll datapath reuses the SPEED_LIMIT and WIDTH_SPEED constants from it.
REQ-027 A sub-module barrier_timer SHALL hold the saturating counter with clear/enable and a terminal-compare output. The FSM and pending counter stay in barrier_ctrl.

Verification (MOTOR_TMO=100, HOLD_CYC=8, PASS_TMO=200, SPEED_LIMIT=60)
REQ-028 done, en_barrier=1, speed=40 -> OPENING. After lim_open -> OPEN. sensor3 pulse -> pending returns to 0, 8 cycles later CLOSING. After lim_closed -> CLOSED.
REQ-029 done, speed=75, en_barrier=1 -> reject and overspeed pulse one cycle each. State remains CLOSED and pending = 0.
REQ-030 Four authorised dones back-to-back -> pending saturates at 3. Three passes -> pending 0, then close after HOLD_CYC.
REQ-031 sensor3 goes high during CLOSING -> OPENING next cycle with motor_up = 1 and motor_down = 0.
REQ-032 No lim_open for 100 cycles in OPENING -> FAULT with fault = 1 and motors off. fault_clr -> CLOSING.
REQ-033 Reset pulsed during OPENING -> all outputs 0 the next cycle, state CLOSED, pending 0.

Source files
------------

// File: rtl/barrier_ctrl_pkg.sv
// Shared types and default constants for the toll barrier controller.
// The toll datapath reuses DefSpeedLimit and DefWidthSpeed from here.
package barrier_ctrl_pkg;

   typedef enum logic [2:0] {
      StClosed  = 3'd0,
      StOpening = 3'd1,
      StOpen    = 3'd2,
      StClosing = 3'd3,
      StFault   = 3'd4
   } state_e;

   localparam int unsigned DefWidthSpeed = 14;
   localparam int unsigned DefSpeedLimit = 60;
   localparam int unsigned DefWidthTmr   = 20;
   localparam int unsigned DefMotorTmo   = 500000;
   localparam int unsigned DefHoldCyc    = 50000;
   localparam int unsigned DefPassTmo    = 2000000;

endpackage

// File: rtl/barrier_timer.sv
// Saturating cycle counter with synchronous clear/enable and a terminal-compare flag.
module barrier_timer #(
   parameter int unsigned WIDTH = 20
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [31:0] term_i,
   output logic        reached_o
);

   localparam logic [31:0] MaxCnt = (WIDTH >= 32) ? 32'hffff_ffff : ((32'd1 << WIDTH) - 32'd1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]      term_eff;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // A terminal beyond the counter range fires at saturation instead of never.
   assign term_eff  = (term_i > MaxCnt) ? MaxCnt : term_i;
   assign reached_o = (32'(cnt_q) >= term_eff);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/barrier_ctrl.sv
// Toll barrier FSM: tracks authorised vehicles, drives the motor and detects
// travel timeouts and limit-switch faults.
module barrier_ctrl
   import barrier_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_SPEED = DefWidthSpeed,
   parameter int unsigned SPEED_LIMIT = DefSpeedLimit,
   parameter int unsigned WIDTH_TMR   = DefWidthTmr,
   parameter int unsigned MOTOR_TMO   = DefMotorTmo,
   parameter int unsigned HOLD_CYC    = DefHoldCyc,
   parameter int unsigned PASS_TMO    = DefPassTmo
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   done,
   input  logic                   en_barrier,
   input  logic [WIDTH_SPEED-1:0] speed,
   input  logic                   sensor3,
   input  logic                   lim_open,
   input  logic                   lim_closed,
   input  logic                   fault_clr,
   output logic                   motor_up,
   output logic                   motor_down,
   output logic                   barrier_open,
   output logic                   reject,
   output logic                   overspeed,
   output logic                   fault,
   output logic [1:0]             pending
);

   state_e      state_q, state_d;
   logic [1:0]  pending_q, pending_d;
   logic        s3_q;
   logic        motor_up_q, motor_down_q, open_q, fault_q, reject_q, over_q;
   logic        spd_ok, live, auth, refuse, pass, restart_open;
   logic        tmr_clr, tmr_en, reached;
   logic [31:0] term;

   assign spd_ok       = (32'(speed) <= SPEED_LIMIT);
   assign live         = (state_q != StFault);
   assign auth         = done & en_barrier & spd_ok & live;
   assign refuse       = done & ~(en_barrier & spd_ok) & live;
   assign pass         = sensor3 & ~s3_q;
   assign restart_open = (state_q == StOpen) & (pass | auth);

   always_comb begin
      term = MOTOR_TMO - 1;
      if (state_q == StOpen) begin
         term = (pending_q == 2'd0) ? (HOLD_CYC - 1) : (PASS_TMO - 1);
      end
   end

   assign tmr_clr = (state_d != state_q) | restart_open;
   assign tmr_en  = (state_q == StOpening) | (state_q == StOpen) | (state_q == StClosing);

   barrier_timer #(
      .WIDTH (WIDTH_TMR)
   ) u_timer (
      .clk_i     (clk),
      .reset_i   (reset),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .term_i    (term),
      .reached_o (reached)
   );

   always_comb begin
      state_d = state_q;
      if (lim_open && lim_closed) begin
         state_d = StFault;
      end else begin
         case (state_q)
            StClosed:  if ((pending_q != 2'd0) || auth) state_d = StOpening;
            StOpening: begin
               if (lim_open)     state_d = StOpen;
               else if (reached) state_d = StFault;
            end
            StOpen: begin
               if (!restart_open && reached && ((pending_q != 2'd0) || !sensor3)) begin
                  state_d = StClosing;
               end
            end
            StClosing: begin
               if (sensor3 || auth) state_d = StOpening;
               else if (lim_closed) state_d = StClosed;
               else if (reached)    state_d = StFault;
            end
            StFault:   if (fault_clr) state_d = StClosing;
            default:   state_d = StClosed;
         endcase
      end
   end

   // Leaving OPEN abandons any vehicles still counted as pending.
   always_comb begin
      pending_d = pending_q;
      if ((state_q == StFault) || (state_d == StFault) ||
          ((state_q == StOpen) && (state_d == StClosing))) begin
         pending_d = 2'd0;
      end else if (auth && !pass) begin
         if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
      end else if (pass && !auth) begin
         if (pending_q != 2'd0) pending_d = pending_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StClosed;
         pending_q    <= 2'd0;
         s3_q         <= 1'b0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
         open_q       <= 1'b0;
         fault_q      <= 1'b0;
         reject_q     <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         s3_q         <= sensor3;
         motor_up_q   <= (state_d == StOpening);
         motor_down_q <= (state_d == StClosing);
         open_q       <= (state_d == StOpen);
         fault_q      <= (state_d == StFault);
         reject_q     <= refuse;
         over_q       <= done & ~spd_ok & live;
      end
   end

   assign motor_up     = motor_up_q;
   assign motor_down   = motor_down_q;
   assign barrier_open = open_q;
   assign fault        = fault_q;
   assign reject       = reject_q;
   assign overspeed    = over_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_barrier_ctrl.sv
// Directed bench for barrier_ctrl with short timeouts (MOTOR 100, HOLD 8, PASS 200).
module tb_barrier_ctrl;
   import barrier_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset, done, en_barrier, sensor3, lim_open, lim_closed, fault_clr;
   logic [13:0] speed;
   logic        motor_up, motor_down, barrier_open, reject, overspeed, fault;
   logic [1:0]  pending;
   int          tests = 0;
   int          fails = 0;

   barrier_ctrl #(
      .WIDTH_SPEED (14),
      .SPEED_LIMIT (60),
      .WIDTH_TMR   (20),
      .MOTOR_TMO   (100),
      .HOLD_CYC    (8),
      .PASS_TMO    (200)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .done         (done),
      .en_barrier   (en_barrier),
      .speed        (speed),
      .sensor3      (sensor3),
      .lim_open     (lim_open),
      .lim_closed   (lim_closed),
      .fault_clr    (fault_clr),
      .motor_up     (motor_up),
      .motor_down   (motor_down),
      .barrier_open (barrier_open),
      .reject       (reject),
      .overspeed    (overspeed),
      .fault        (fault),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   // {up, down, open, fault, reject, overspeed, pending[1:0]}
   function automatic logic [7:0] outs();
      return {motor_up, motor_down, barrier_open, fault, reject, overspeed, pending};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic auth_done();
      done = 1'b1; en_barrier = 1'b1; speed = 14'd40;
      tick(1);
      done = 1'b0;
   endtask

   task automatic pass_vehicle();
      sensor3 = 1'b1;
      tick(1);
      sensor3 = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      reset = 1'b1; done = 1'b0; en_barrier = 1'b0; speed = '0; sensor3 = 1'b0;
      lim_open = 1'b0; lim_closed = 1'b0; fault_clr = 1'b0;
      tick(2);
      reset = 1'b0;
      tests++;
      if (outs() !== 8'b000000_00) begin
         $display("FAIL reset_outputs: got %b want %b", outs(), 8'b000000_00); fails++;
      end
      tests++;
      if (dut.state_q !== StClosed) begin
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, StClosed); fails++;
      end
   endtask

   task automatic test_basic_cycle();
      auth_done();
      tests++;
      if (outs() !== 8'b100000_01) begin
         $display("FAIL basic_opening: got %b want %b", outs(), 8'b100000_01); fails++;
      end
      lim_open = 1'b1;
      tick(1);
      lim_open = 1'b0;
      tests++;
      if (outs() !== 8'b001000_01) begin
         $display("FAIL basic_open: got %b want %b", outs(), 8'b001000_01); fails++;
      end
      sensor3 = 1'b1;
      tick(1);
      sensor3 = 1'b0;
      tests++;
      if (outs() !== 8'b001000_00) begin
         $display("FAIL basic_pass: got %b want %b", outs(), 8'b001000_00); fails++;
      end
      tick(7);
      tests++;
      if (outs() !== 8'b001000_00) begin
         $display("FAIL basic_hold7: got %b want %b", outs(), 8'b001000_00); fails++;
      end
      tick(1);
      tests++;
      if (outs() !== 8'b010000_00) begin
         $display("FAIL basic_closing: got %b want %b", outs(), 8'b010000_00); fails++;
      end
      lim_closed = 1'b1;
      tick(1);
      lim_closed = 1'b0;
      tests++;
      if (outs() !== 8'b000000_00 || dut.state_q !== StClosed) begin
         $display("FAIL basic_closed: got %b want %b", outs(), 8'b000000_00); fails++;
      end
   endtask

   task automatic test_reject();
      done = 1'b1; en_barrier = 1'b1; speed = 14'd75;
      tick(1);
      done = 1'b0;
      tests++;
      if (outs() !== 8'b000011_00) begin
         $display("FAIL reject_overspeed: got %b want %b", outs(), 8'b000011_00); fails++;
      end
      tick(1);
      tests++;
      if (outs() !== 8'b000000_00 || dut.state_q !== StClosed) begin
         $display("FAIL reject_one_cycle: got %b want %b", outs(), 8'b000000_00); fails++;
      end
      done = 1'b1; en_barrier = 1'b0; speed = 14'd60;
      tick(1);
      done = 1'b0;
      tests++;
      if (outs() !== 8'b000010_00) begin
         $display("FAIL reject_no_auth: got %b want %b", outs(), 8'b000010_00); fails++;
      end
      tick(1);
   endtask

   task automatic test_saturate();
      done = 1'b1; en_barrier = 1'b1; speed = 14'd60;
      tick(4);
      done = 1'b0;
      tests++;
      if (outs() !== 8'b100000_11) begin
         $display("FAIL sat_pending3: got %b want %b", outs(), 8'b100000_11); fails++;
      end
      lim_open = 1'b1;
      tick(1);
      lim_open = 1'b0;
      pass_vehicle();
      pass_vehicle();
      tests++;
      if (outs() !== 8'b001000_01) begin
         $display("FAIL sat_two_passes: got %b want %b", outs(), 8'b001000_01); fails++;
      end
      pass_vehicle();
      tick(6);
      tests++;
      if (outs() !== 8'b001000_00) begin
         $display("FAIL sat_hold: got %b want %b", outs(), 8'b001000_00); fails++;
      end
      tick(1);
      tests++;
      if (outs() !== 8'b010000_00) begin
         $display("FAIL sat_closing: got %b want %b", outs(), 8'b010000_00); fails++;
      end
      lim_closed = 1'b1;
      tick(1);
      lim_closed = 1'b0;
   endtask

   task automatic test_pass_timeout_reversal();
      auth_done();
      lim_open = 1'b1;
      tick(1);
      lim_open = 1'b0;
      tick(199);
      tests++;
      if (outs() !== 8'b001000_01) begin
         $display("FAIL ptmo_still_open: got %b want %b", outs(), 8'b001000_01); fails++;
      end
      tick(1);
      tests++;
      if (outs() !== 8'b010000_00) begin
         $display("FAIL ptmo_closing: got %b want %b", outs(), 8'b010000_00); fails++;
      end
      sensor3 = 1'b1;
      tick(1);
      sensor3 = 1'b0;
      tests++;
      if (outs() !== 8'b100000_00) begin
         $display("FAIL reversal_opening: got %b want %b", outs(), 8'b100000_00); fails++;
      end
      lim_open = 1'b1;
      tick(1);
      lim_open = 1'b0;
      tick(8);
      lim_closed = 1'b1;
      tick(1);
      lim_closed = 1'b0;
      tests++;
      if (outs() !== 8'b000000_00 || dut.state_q !== StClosed) begin
         $display("FAIL reversal_closed: got %b want %b", outs(), 8'b000000_00); fails++;
      end
   endtask

   task automatic test_motor_timeout();
      auth_done();
      tick(99);
      tests++;
      if (outs() !== 8'b100000_01) begin
         $display("FAIL mtmo_opening99: got %b want %b", outs(), 8'b100000_01); fails++;
      end
      tick(1);
      tests++;
      if (outs() !== 8'b000100_00) begin
         $display("FAIL mtmo_fault: got %b want %b", outs(), 8'b000100_00); fails++;
      end
      auth_done();
      tests++;
      if (outs() !== 8'b000100_00) begin
         $display("FAIL fault_ignores_done: got %b want %b", outs(), 8'b000100_00); fails++;
      end
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      tests++;
      if (outs() !== 8'b010000_00) begin
         $display("FAIL fault_clr_closing: got %b want %b", outs(), 8'b010000_00); fails++;
      end
      lim_closed = 1'b1;
      tick(2);
      lim_closed = 1'b0;
   endtask

   task automatic test_both_limits();
      lim_open = 1'b1; lim_closed = 1'b1;
      tick(1);
      lim_open = 1'b0; lim_closed = 1'b0;
      tests++;
      if (outs() !== 8'b000100_00) begin
         $display("FAIL both_limits_fault: got %b want %b", outs(), 8'b000100_00); fails++;
      end
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      lim_closed = 1'b1;
      tick(1);
      lim_closed = 1'b0;
   endtask

   task automatic test_reset_mid_travel();
      auth_done();
      tests++;
      if (outs() !== 8'b100000_01) begin
         $display("FAIL rst_pre_opening: got %b want %b", outs(), 8'b100000_01); fails++;
      end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tests++;
      if (outs() !== 8'b000000_00 || dut.state_q !== StClosed) begin
         $display("FAIL rst_mid_travel: got %b want %b", outs(), 8'b000000_00); fails++;
      end
      tick(3);
      tests++;
      if (outs() !== 8'b000000_00) begin
         $display("FAIL rst_no_reopen: got %b want %b", outs(), 8'b000000_00); fails++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_cycle();
      test_reject();
      test_saturate();
      test_pass_timeout_reversal();
      test_motor_timeout();
      test_both_limits();
      test_reset_mid_travel();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
